pulse_width_modulator: RTL and testbench



---
 rtl/pwm_pkg.sv | 13 +
 rtl/pwm_counter.sv | 99 +++++++++
 rtl/pulse_width_modulator.sv | 55 +++++
 tb/tb_pulse_width_modulator.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the pulse_width_modulator block.
//   PWM_BITS_DEFAULT : default counter / compare / width size
//   pwm_dir_t        : counting direction of the PWM counter
package pwm_pkg;

    localparam int unsigned PWM_BITS_DEFAULT = 11;

    typedef enum logic {
        PWM_DIR_UP   = 1'b0,
        PWM_DIR_DOWN = 1'b1
    } pwm_dir_t;

endpackage : pwm_pkg

// File: rtl/pwm_counter.sv
// Period counter for the PWM generator: edge-aligned wrap or center-aligned
// up/down turnaround, plus the sample-slot strobe.
// Build option: define PWM_DUAL_SLOPE_EN to compile in dual/double-slope
// counting; otherwise the mode inputs are ignored and there is no dir register.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   dual_slope_en    : 1 = up/down counting
//   double_slope_en  : dual mode only, also strobe at the top turnaround
//   compare_max      : top count M
//   cnt              : current count
//   dir              : current direction (always UP in single-slope builds)
//   pulse_done       : combinational, last cycle of the current (half-)period
module pwm_counter
    import pwm_pkg::*;
#(
    parameter int unsigned BITS = PWM_BITS_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dual_slope_en,
    input  logic            double_slope_en,
    input  logic [BITS-1:0] compare_max,
    output logic [BITS-1:0] cnt,
    output pwm_dir_t        dir,
    output logic            pulse_done
);

    logic [BITS-1:0] cnt_q;
    logic [BITS-1:0] cnt_d;
    pwm_dir_t        dir_q;
    pwm_dir_t        dir_d;
    logic            top_c;
    logic            done_c;

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef PWM_DUAL_SLOPE_EN
    // Direction register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q <= PWM_DIR_UP;
        end else begin
            dir_q <= dir_d;
        end
    end
`else
    // Single-slope only: direction is constant and the mode inputs are unused.
    logic unused_mode;
    assign dir_q       = PWM_DIR_UP;
    assign unused_mode = dual_slope_en ^ double_slope_en;
`endif

    // Next count / direction and the sample strobe.
    // '>=' makes a compare_max lowered below cnt behave as top reached.
    always_comb begin
        cnt_d  = cnt_q;
        dir_d  = PWM_DIR_UP;
        done_c = 1'b0;
        top_c  = (cnt_q >= compare_max);
`ifdef PWM_DUAL_SLOPE_EN
        if (dual_slope_en) begin
            dir_d = dir_q;
            if (dir_q == PWM_DIR_UP) begin
                if (top_c) begin
                    // Hold at the top for a second cycle, then count down.
                    dir_d  = PWM_DIR_DOWN;
                    done_c = double_slope_en;
                end else begin
                    cnt_d = cnt_q + BITS'(1);
                end
            end else begin
                if (cnt_q == '0) begin
                    // Hold at zero for a second cycle, then count up.
                    dir_d  = PWM_DIR_UP;
                    done_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - BITS'(1);
                end
            end
        end else
`endif
        begin
            done_c = top_c;
            cnt_d  = top_c ? '0 : cnt_q + BITS'(1);
        end
    end

    assign cnt        = cnt_q;
    assign dir        = dir_q;
    assign pulse_done = done_c & rst_n;

endmodule : pwm_counter

// File: rtl/pulse_width_modulator.sv
// Counter-based PWM generator for the noise-shaping DAC output stage.
// Build option: define PWM_DUAL_SLOPE_EN for dual/double-slope support.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   dual_slope_en    : 1 = center-aligned (up/down) counting
//   double_slope_en  : dual mode only, also sample at the top turnaround
//   compare_max      : top count M, sampled every cycle
//   pulse_width      : requested high time W, captured when pulse_done = 1
//   pulse_done       : last cycle of the current (half-)period
//   pwm_out          : modulated output, cnt < captured width
module pulse_width_modulator
    import pwm_pkg::*;
#(
    parameter int unsigned BITS = PWM_BITS_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dual_slope_en,
    input  logic            double_slope_en,
    input  logic [BITS-1:0] compare_max,
    input  logic [BITS-1:0] pulse_width,
    output logic            pulse_done,
    output logic            pwm_out
);

    logic [BITS-1:0] cnt;
    logic [BITS-1:0] w_q;
    pwm_dir_t        unused_dir;

    pwm_counter #(
        .BITS (BITS)
    ) u_counter (
        .clk             (clk),
        .rst_n           (rst_n),
        .dual_slope_en   (dual_slope_en),
        .double_slope_en (double_slope_en),
        .compare_max     (compare_max),
        .cnt             (cnt),
        .dir             (unused_dir),
        .pulse_done      (pulse_done)
    );

    // Width register: new width applies from the first cycle of the next slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q <= '0;
        end else if (pulse_done) begin
            w_q <= pulse_width;
        end
    end

    // Compare decoded from registers only.
    assign pwm_out = (cnt < w_q);

endmodule : pulse_width_modulator

// File: tb/tb_pulse_width_modulator.sv
// Self-checking bench for pulse_width_modulator: table of steady-state
// period/width vectors plus hand sequences for the multi-cycle corner cases.
module tb_pulse_width_modulator;

    localparam int unsigned BITS = 11;

    logic            clk;
    logic            rst_n;
    logic            dual_slope_en;
    logic            double_slope_en;
    logic [BITS-1:0] compare_max;
    logic [BITS-1:0] pulse_width;
    logic            pulse_done;
    logic            pwm_out;

    int n_checks;
    int n_fail;

    pulse_width_modulator #(
        .BITS (BITS)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .dual_slope_en   (dual_slope_en),
        .double_slope_en (double_slope_en),
        .compare_max     (compare_max),
        .pulse_width     (pulse_width),
        .pulse_done      (pulse_done),
        .pwm_out         (pwm_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        bit    dual;
        int    m;
        int    w;
        int    exp_period;
        int    exp_high;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_pat(input string name, input logic [255:0] act,
                             input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance until pulse_done is seen, bounded.
    task automatic wait_done(input string name);
        int n;
        #1;
        n = 0;
        while (!pulse_done && n < 300) begin
            tick();
            n++;
        end
        check_int({name, " done seen"}, int'(pulse_done), 1);
    endtask

    // From a pulse_done cycle, run one full (half-)period up to the next one.
    task automatic run_period(output int period, output int highs,
                              output logic [255:0] pat);
        period = 0;
        highs  = 0;
        pat    = '0;
        do begin
            tick();
            pat[period] = pwm_out;
            if (pwm_out) highs++;
            period++;
        end while (!pulse_done && period < 256);
    endtask

    // Expected pwm per cycle: count value at index i compared against W.
    function automatic logic [255:0] exp_pat(input bit dual, input int m,
                                             input int w, input int period);
        logic [255:0] p;
        int cv;
        p = '0;
        for (int i = 0; i < period; i++) begin
            cv = (dual && i > m) ? (2 * m + 1 - i) : i;
            p[i] = (cv < w);
        end
        return p;
    endfunction

    initial begin
        int           period;
        int           highs;
        int           n;
        logic [255:0] pat;
        bit           eff_dual;

        n_checks = 0;
        n_fail   = 0;
        clk             = 1'b0;
        rst_n           = 1'b0;
        dual_slope_en   = 1'b0;
        double_slope_en = 1'b0;
        compare_max     = '0;
        pulse_width     = BITS'(5);

        vecs[0] = '{"ss_m9_w3",    1'b0, 9, 3,    10, 3};
        vecs[1] = '{"ss_m9_w0",    1'b0, 9, 0,    10, 0};
        vecs[2] = '{"ss_m9_w10",   1'b0, 9, 10,   10, 10};
        vecs[3] = '{"ss_m9_w2047", 1'b0, 9, 2047, 10, 10};
        vecs[4] = '{"ss_m0_w0",    1'b0, 0, 0,    1,  0};
        vecs[5] = '{"ss_m0_w1",    1'b0, 0, 1,    1,  1};
        vecs[6] = '{"ss_m5_w4",    1'b0, 5, 4,    6,  4};
`ifdef PWM_DUAL_SLOPE_EN
        vecs[7] = '{"ds_m4_w2",    1'b1, 4, 2,    10, 4};
        vecs[8] = '{"ds_m0_w1",    1'b1, 0, 1,    2,  2};
`else
        vecs[7] = '{"ds_m4_w2",    1'b1, 4, 2,    5,  2};
        vecs[8] = '{"ds_m0_w1",    1'b1, 0, 1,    1,  1};
`endif

        // Reset state: M=0 would strobe every cycle if not gated by reset.
        repeat (2) @(posedge clk);
        #1;
        check_int("reset pwm_out", int'(pwm_out), 0);
        check_int("reset pulse_done", int'(pulse_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        foreach (vecs[k]) begin
`ifdef PWM_DUAL_SLOPE_EN
            eff_dual = vecs[k].dual;
`else
            eff_dual = 1'b0;
`endif
            dual_slope_en = vecs[k].dual;
            compare_max   = BITS'(vecs[k].m);
            pulse_width   = BITS'(vecs[k].w);
            wait_done(vecs[k].name);
            run_period(period, highs, pat);
            check_int({vecs[k].name, " period"}, period, vecs[k].exp_period);
            check_int({vecs[k].name, " highs"}, highs, vecs[k].exp_high);
            check_pat({vecs[k].name, " shape"}, pat,
                      exp_pat(eff_dual, vecs[k].m, vecs[k].w, vecs[k].exp_period));
        end

`ifdef PWM_DUAL_SLOPE_EN
        // Double-slope: sitting on a bottom strobe, W=1 governs the up half,
        // W=3 loaded at the top governs the down half.
        compare_max     = BITS'(4);
        double_slope_en = 1'b1;
        pulse_width     = BITS'(1);
        run_period(period, highs, pat);
        check_int("dbl up period", period, 5);
        check_int("dbl up highs", highs, 1);
        pulse_width = BITS'(3);
        run_period(period, highs, pat);
        check_int("dbl down period", period, 5);
        check_int("dbl down highs", highs, 3);
        check_pat("dbl down shape", pat, 256'h1c);
        pulse_width = BITS'(1);
        run_period(period, highs, pat);
        check_int("dbl up2 highs", highs, 1);
        double_slope_en = 1'b0;
`endif

        // Width change mid-period has no effect until the next strobe.
        dual_slope_en = 1'b0;
        compare_max   = BITS'(9);
        pulse_width   = BITS'(3);
        wait_done("midw");
        tick();
        highs = int'(pwm_out);
        pulse_width = BITS'(7);
        for (int i = 0; i < 9; i++) begin
            tick();
            if (pwm_out) highs++;
        end
        check_int("midw old highs", highs, 3);
        check_int("midw end done", int'(pulse_done), 1);
        run_period(period, highs, pat);
        check_int("midw new highs", highs, 7);

        // compare_max lowered 100 -> 5 while cnt = 50.
        pulse_width = BITS'(3);
        compare_max = BITS'(100);
        wait_done("mlow");
        repeat (51) tick();
        check_int("mlow done before", int'(pulse_done), 0);
        compare_max = BITS'(5);
        #1;
        check_int("mlow done at cut", int'(pulse_done), 1);
        tick();
        check_int("mlow wrap pwm", int'(pwm_out), 1);
        check_int("mlow wrap done", int'(pulse_done), 0);
        n = 0;
        while (!pulse_done && n < 300) begin
            tick();
            n++;
        end
        check_int("mlow next period", n, 5);

        // Asynchronous reset mid-period, then restart from 0 with width 0.
        compare_max = BITS'(9);
        wait_done("rst");
        tick();
        tick();
        check_int("rst pre pwm", int'(pwm_out), 1);
        rst_n       = 1'b0;
        compare_max = '0;
        #1;
        check_int("rst pwm low", int'(pwm_out), 0);
        check_int("rst done low", int'(pulse_done), 0);
        compare_max = BITS'(9);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n     = 0;
        highs = 0;
        #1;
        while (!pulse_done && n < 300) begin
            tick();
            n++;
            if (pwm_out) highs++;
        end
        check_int("rst restart cycles", n, 9);
        check_int("rst restart highs", highs, 0);
        run_period(period, highs, pat);
        check_int("rst after period", period, 10);
        check_int("rst after highs", highs, 3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule : tb_pulse_width_modulator
